// File: rtl/multicycle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer_pkg
//   Constants shared by the multi-cycle sequencer and the combinational main
//   decoder: opcode values, FSM state encodings, PC-source and write-back
//   select encodings, and opcode class helpers.
// -----------------------------------------------------------------------------
package multicycle_sequencer_pkg;

  // Opcodes
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_ANDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_LB   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_BLT  = 4'd10;
  localparam logic [3:0] OP_BGE  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_CALL = 4'd13;
  localparam logic [3:0] OP_RET  = 4'd14;
  localparam logic [3:0] OP_SV   = 4'd15;

  // FSM states (values are visible on the state port)
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // PC source select
  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RET    = 2'd3;

  // Register write-back select
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC1 = 2'd2;

  // Opcode classes
  function automatic logic is_alu(input logic [3:0] op);
    return (op <= OP_ANDI);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LB);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SV);
  endfunction

  // Branches occupy 8..11, i.e. the 2'b10 quadrant of the opcode space
  function automatic logic is_branch(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
//   Counts cycles spent waiting on the data memory and flags the last allowed
//   wait cycle.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, clears the count
//   i_clear    : clear the count (takes priority over i_inc)
//   i_inc      : advance the count by one
//   o_timeout  : count has reached WDT_CYCLES-1 (final permitted wait cycle)
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int WDT_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_timeout
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_timeout = (r_cnt == CNT_W'(WDT_CYCLES - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//   Control FSM that walks each instruction through FETCH/DECODE/EXEC/MEM/WB
//   and produces cycle-accurate datapath strobes. Outputs are a combinational
//   decode of the registered state, the latched opcode and the ready inputs.
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset; forces all strobes low
//   opcode, mode : instruction fields from IR (valid from DECODE onward)
//   imem_ready   : instruction word valid (looked at in FETCH only)
//   dmem_ready   : data access complete (looked at in MEM only)
//   branch_taken : comparator result (looked at in EXEC only)
//   ir_wr, pc_wr, pc_src, reg_wr_en, wb_sel, mem_rd_en, mem_wr_en : datapath
//   instr_done   : pulse on an instruction's final cycle
//   mem_err      : pulse when a data access times out
//   state        : current FSM state
// -----------------------------------------------------------------------------
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int WDT_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       mode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       branch_taken,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       reg_wr_en,
  output logic [1:0] wb_sel,
  output logic       mem_rd_en,
  output logic       mem_wr_en,
  output logic       instr_done,
  output logic       mem_err,
  output logic [2:0] state
);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_op_q;
  logic       r_mode_q;
  logic       w_tmr_clear;
  logic       w_tmr_inc;
  logic       w_timeout;

  // The mode bit is held alongside the opcode for the datapath; the sequence
  // itself does not depend on it.
  logic       w_unused_mode;
  assign w_unused_mode = r_mode_q;

  mem_wait_timer #(
    .WDT_CYCLES (WDT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mem_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_tmr_clear),
    .i_inc     (w_tmr_inc),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_FETCH;
      r_op_q   <= '0;
      r_mode_q <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE) begin
        r_op_q   <= opcode;
        r_mode_q <= mode;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    ir_wr        = 1'b0;
    pc_wr        = 1'b0;
    pc_src       = PC_SRC_INC;
    reg_wr_en    = 1'b0;
    wb_sel       = WB_SEL_ALU;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    instr_done   = 1'b0;
    mem_err      = 1'b0;
    w_tmr_clear  = 1'b1;
    w_tmr_inc    = 1'b0;

    case (r_state)
      ST_FETCH: begin
        ir_wr = imem_ready;
        if (imem_ready) begin
          w_state_next = ST_DECODE;
        end
      end

      // op_q is loaded at the end of this cycle, so decide on the raw opcode
      ST_DECODE: begin
        case (opcode)
          OP_JMP: begin
            pc_wr        = 1'b1;
            pc_src       = PC_SRC_JUMP;
            instr_done   = 1'b1;
            w_state_next = ST_FETCH;
          end
          OP_RET: begin
            pc_wr        = 1'b1;
            pc_src       = PC_SRC_RET;
            instr_done   = 1'b1;
            w_state_next = ST_FETCH;
          end
          OP_CALL: w_state_next = ST_WB;
          default: w_state_next = ST_EXEC;
        endcase
      end

      ST_EXEC: begin
        if (is_branch(r_op_q)) begin
          pc_wr        = 1'b1;
          pc_src       = branch_taken ? PC_SRC_BRANCH : PC_SRC_INC;
          instr_done   = 1'b1;
          w_state_next = ST_FETCH;
        end else if (is_load(r_op_q) || is_store(r_op_q)) begin
          w_state_next = ST_MEM;
        end else begin
          w_state_next = ST_WB;
        end
      end

      // Strobes stay up for every MEM cycle, including a timeout cycle
      ST_MEM: begin
        mem_rd_en   = is_load(r_op_q);
        mem_wr_en   = is_store(r_op_q);
        w_tmr_clear = 1'b0;
        if (dmem_ready) begin
          w_tmr_clear = 1'b1;
          if (is_load(r_op_q)) begin
            w_state_next = ST_WB;
          end else begin
            pc_wr        = 1'b1;
            instr_done   = 1'b1;
            w_state_next = ST_FETCH;
          end
        end else if (w_timeout) begin
          // Aborted access: retire the instruction without write-back
          w_tmr_clear  = 1'b1;
          mem_err      = 1'b1;
          pc_wr        = 1'b1;
          instr_done   = 1'b1;
          w_state_next = ST_FETCH;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end

      ST_WB: begin
        reg_wr_en    = 1'b1;
        pc_wr        = 1'b1;
        instr_done   = 1'b1;
        w_state_next = ST_FETCH;
        if (r_op_q == OP_CALL) begin
          wb_sel = WB_SEL_PC1;
          pc_src = PC_SRC_JUMP;
        end else if (is_load(r_op_q)) begin
          wb_sel = WB_SEL_MEM;
        end
      end

      default: w_state_next = ST_FETCH;
    endcase

    // Reset is synchronous, so the state register may still hold a mid-
    // instruction value in the reset cycle; suppress everything it would drive.
    if (reset) begin
      ir_wr      = 1'b0;
      pc_wr      = 1'b0;
      pc_src     = PC_SRC_INC;
      reg_wr_en  = 1'b0;
      wb_sel     = WB_SEL_ALU;
      mem_rd_en  = 1'b0;
      mem_wr_en  = 1'b0;
      instr_done = 1'b0;
      mem_err    = 1'b0;
    end
  end

  assign state = reset ? ST_FETCH : r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//   Per-cycle vectors {inputs, expected outputs}: a table of short
//   instructions followed by hand-written timeout and reset sequences.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  typedef struct packed {
    logic       rst;
    logic [3:0] op;
    logic       md;
    logic       imr;
    logic       dmr;
    logic       bt;
  } in_t;

  typedef struct packed {
    logic [2:0] st;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rwe;
    logic [1:0] wbs;
    logic       mrd;
    logic       mwr;
    logic       dn;
    logic       err;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       mode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       branch_taken;
  logic       ir_wr;
  logic       pc_wr;
  logic [1:0] pc_src;
  logic       reg_wr_en;
  logic [1:0] wb_sel;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic       instr_done;
  logic       mem_err;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_sequencer #(.WDT_CYCLES(16), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mode         (mode),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .ir_wr        (ir_wr),
    .pc_wr        (pc_wr),
    .pc_src       (pc_src),
    .reg_wr_en    (reg_wr_en),
    .wb_sel       (wb_sel),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .instr_done   (instr_done),
    .mem_err      (mem_err),
    .state        (state)
  );

  function automatic in_t mk_in(input logic rst, input logic [3:0] op, input logic md,
                                input logic imr, input logic dmr, input logic bt);
    in_t v;
    v = '{rst: rst, op: op, md: md, imr: imr, dmr: dmr, bt: bt};
    return v;
  endfunction

  function automatic out_t mk_out(input logic [2:0] st, input logic irw, input logic pcw,
                                  input logic [1:0] pcs, input logic rwe, input logic [1:0] wbs,
                                  input logic mrd, input logic mwr, input logic dn,
                                  input logic err);
    out_t v;
    v = '{st: st, irw: irw, pcw: pcw, pcs: pcs, rwe: rwe, wbs: wbs,
          mrd: mrd, mwr: mwr, dn: dn, err: err};
    return v;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  // Drive on the falling edge, compare 1 ns later, before the next rising edge
  task automatic run_vec(input vec_t v, input string tag);
    out_t act;
    @(negedge clk);
    reset        = v.i.rst;
    opcode       = v.i.op;
    mode         = v.i.md;
    imem_ready   = v.i.imr;
    dmem_ready   = v.i.dmr;
    branch_taken = v.i.bt;
    #1;
    act = '{st: state, irw: ir_wr, pcw: pc_wr, pcs: pc_src, rwe: reg_wr_en, wbs: wb_sel,
            mrd: mem_rd_en, mwr: mem_wr_en, dn: instr_done, err: mem_err};
    n_checks++;
    if (act !== v.o) begin
      $display("FAIL %s: got st=%0d irw=%b pcw=%b pcs=%0d rwe=%b wbs=%0d mrd=%b mwr=%b dn=%b err=%b, expected st=%0d irw=%b pcw=%b pcs=%0d rwe=%b wbs=%0d mrd=%b mwr=%b dn=%b err=%b",
               tag, act.st, act.irw, act.pcw, act.pcs, act.rwe, act.wbs, act.mrd, act.mwr,
               act.dn, act.err, v.o.st, v.o.irw, v.o.pcw, v.o.pcs, v.o.rwe, v.o.wbs,
               v.o.mrd, v.o.mwr, v.o.dn, v.o.err);
    end else begin
      n_pass++;
      $display("%s: st=%0d ok", tag, act.st);
    end
  endtask

  task automatic step(input in_t i, input out_t o, input string tag);
    vec_t v;
    v.i = i;
    v.o = o;
    run_vec(v, tag);
  endtask

  // Fetch + decode + exec of a memory op, then WDT_CYCLES cycles with no ready
  task automatic timeout_seq(input logic [3:0] op, input logic ld, input string name);
    step(mk_in(0, 4'd0, 0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), {name, " fetch"});
    step(mk_in(0, op,   0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), {name, " decode"});
    step(mk_in(0, 4'd0, 0, 1, 0, 0), mk_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), {name, " exec"});
    for (int k = 0; k < 16; k++) begin
      if (k == 15)
        step(mk_in(0, 4'd0, 0, 1, 0, 0), mk_out(3, 0, 1, 0, 0, 0, ld, !ld, 1, 1),
             $sformatf("%s mem%0d timeout", name, k));
      else
        step(mk_in(0, 4'd0, 0, 1, 0, 0), mk_out(3, 0, 0, 0, 0, 0, ld, !ld, 0, 0),
             $sformatf("%s mem%0d wait", name, k));
    end
    // No write-back after an abort: straight back to FETCH (stalled here)
    step(mk_in(0, 4'd0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {name, " back to fetch"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t idle;
    idle = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1; opcode = '0; mode = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;

    // Reset: strobes forced low even with ready inputs high
    add(mk_in(1, 4'd0, 0, 1, 0, 0), idle);
    add(mk_in(1, 4'd0, 0, 1, 1, 1), idle);
    // ADD: opcode input changes after DECODE to check the latched copy is used
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_ADD,  0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_JMP,  0, 1, 1, 1), mk_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_JMP,  0, 1, 0, 0), mk_out(4, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    // FETCH stall
    add(mk_in(0, 4'd0,    0, 0, 1, 0), idle);
    // LW, two wait cycles
    add(mk_in(0, 4'd0,    1, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_LW,   1, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    1, 1, 0, 0), mk_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    1, 1, 0, 0), mk_out(3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(mk_in(0, 4'd0,    1, 1, 0, 0), mk_out(3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(mk_in(0, 4'd0,    1, 1, 1, 0), mk_out(3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(mk_in(0, 4'd0,    1, 1, 0, 0), mk_out(4, 0, 1, 0, 1, 1, 0, 0, 1, 0));
    // BEQ taken / not taken
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_BEQ,  0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    0, 1, 0, 1), mk_out(2, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    add(mk_in(0, 4'd0,    0, 1, 0, 1), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_BEQ,  0, 1, 0, 1), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(2, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    // CALL, JMP, RET
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_CALL, 0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(4, 0, 1, 2, 1, 2, 0, 0, 1, 0));
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_JMP,  0, 1, 0, 0), mk_out(1, 0, 1, 2, 0, 0, 0, 0, 1, 0));
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_RET,  0, 1, 0, 0), mk_out(1, 0, 1, 3, 0, 0, 0, 0, 1, 0));
    // SV, ready immediately
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_SV,   0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    0, 1, 1, 0), mk_out(3, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    // LB, ready immediately
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_LB,   0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    0, 1, 1, 0), mk_out(3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(4, 0, 1, 0, 1, 1, 0, 0, 1, 0));
    // ANDI
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, OP_ANDI, 0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    0, 1, 1, 1), mk_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 4'd0,    0, 1, 0, 0), mk_out(4, 0, 1, 0, 1, 0, 0, 0, 1, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      run_vec(tbl[r], $sformatf("row%0d", r));
    end

    // Store and load timeouts
    timeout_seq(OP_SW, 1'b0, "sw_timeout");
    timeout_seq(OP_LW, 1'b1, "lw_timeout");

    // After a timeout the wait counter must start again from zero
    step(mk_in(0, 4'd0,  0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sw2 fetch");
    step(mk_in(0, OP_SW, 0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw2 decode");
    step(mk_in(0, 4'd0,  0, 1, 0, 0), mk_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw2 exec");
    step(mk_in(0, 4'd0,  0, 1, 0, 0), mk_out(3, 0, 0, 0, 0, 0, 0, 1, 0, 0), "sw2 mem0");
    step(mk_in(0, 4'd0,  0, 1, 0, 0), mk_out(3, 0, 0, 0, 0, 0, 0, 1, 0, 0), "sw2 mem1");
    step(mk_in(0, 4'd0,  0, 1, 1, 0), mk_out(3, 0, 1, 0, 0, 0, 0, 1, 1, 0), "sw2 mem2 ready");

    // Reset in the second MEM cycle of SV, then a clean ADD
    step(mk_in(0, 4'd0,   0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sv_rst fetch");
    step(mk_in(0, OP_SV,  0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sv_rst decode");
    step(mk_in(0, 4'd0,   0, 1, 0, 0), mk_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sv_rst exec");
    step(mk_in(0, 4'd0,   0, 1, 0, 0), mk_out(3, 0, 0, 0, 0, 0, 0, 1, 0, 0), "sv_rst mem0");
    step(mk_in(1, 4'd0,   0, 1, 1, 0), idle,                                    "sv_rst mem1 reset");
    step(mk_in(0, 4'd0,   0, 1, 0, 0), mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "add fetch");
    step(mk_in(0, OP_ADD, 0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "add decode");
    step(mk_in(0, 4'd0,   0, 1, 0, 0), mk_out(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "add exec");
    step(mk_in(0, 4'd0,   0, 1, 0, 0), mk_out(4, 0, 1, 0, 1, 0, 0, 0, 1, 0), "add wb");
    step(mk_in(0, 4'd0,   0, 0, 0, 0), idle,                                    "add back to fetch");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and gates the per-stage enables the datapath uses (IR load, PC write, register write, data-memory read/write). It consumes the same opcode/mode fields the combinational main decoder uses. It sits beside that decoder and turns its static per-opcode controls into cycle-accurate strobes. It also handles the instruction- and data-memory ready handshakes, including a data-memory timeout.

Parameters:
WDT_CYCLES, 16, max cycles spent in MEM waiting for dmem_ready before abort (>=2)
CNT_W, 5, width of the MEM wait counter (must hold WDT_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  4  instruction opcode from IR; valid from DECODE onward
mode  input  1  instruction mode bit from IR
imem_ready  input  1  instruction word valid this cycle
dmem_ready  input  1  data access complete this cycle
branch_taken  input  1  comparator result from ALU, sampled in EXEC
ir_wr  output  1  load IR
pc_wr  output  1  write PC this cycle
pc_src  output  2  0=PC+1, 1=branch target, 2=jump/call target, 3=return register
reg_wr_en  output  1  register-file write strobe
wb_sel  output  2  0=ALU, 1=memory, 2=PC+1
mem_rd_en  output  1  data-memory read strobe
mem_wr_en  output  1  data-memory write strobe
instr_done  output  1  one-cycle pulse on an instruction's final cycle
mem_err  output  1  one-cycle pulse on a MEM timeout
state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4

Behaviour:
- Reset (synchronous): state=FETCH, op_q=0, mode_q=0, wait counter=0. While reset is high, every strobe output is forced to 0: ir_wr, pc_wr, reg_wr_en, mem_rd_en, mem_wr_en, instr_done, mem_err. pc_src=0, wb_sel=0. state reads 0.
- Outputs: combinational decode of registered state, latched op_q/mode_q and the ready inputs. No additional output latency.
- FETCH: ir_wr = imem_ready. Stay in FETCH while imem_ready=0. Go to DECODE when it is 1.
- DECODE: latch op_q=opcode and mode_q=mode.
  - JMP(12): pc_wr=1, pc_src=2, done → FETCH.
  - RET(14): pc_wr=1, pc_src=3, done → FETCH.
  - CALL(13): → WB.
  - All other opcodes: → EXEC.
- EXEC:
  - Branch(8–11): pc_wr=1, pc_src = branch_taken ? 1 : 0, done → FETCH.
  - LW(5), LB(6), SW(7), SV(15): → MEM.
  - R-type(0–2), ADDI(3), ANDI(4): → WB.
- MEM:
  - mem_rd_en=1 for loads; mem_wr_en=1 for SW/SV. Strobes are held for every MEM cycle.
  - If dmem_ready=1: loads → WB; stores do pc_wr=1, pc_src=0, done → FETCH.
  - If dmem_ready=0: counter increments.
  - If counter==WDT_CYCLES-1 and dmem_ready=0: mem_err=1, strobes still asserted that cycle, pc_wr=1, pc_src=0, instr_done=1, → FETCH. No register write occurs for an aborted load.
  - Counter clears on every MEM exit.
- WB: reg_wr_en=1.
  - wb_sel=0 for ALU ops, 1 for loads.
  - CALL: wb_sel=2 and pc_src=2.
  - Others: pc_src=0.
  - pc_wr=1, done → FETCH.
- Cycle counts with zero wait: ALU 4, load 5, store 4, branch 3, JMP/RET 2, CALL 3.
- dmem_ready and imem_ready are ignored outside MEM and FETCH respectively.
- branch_taken is ignored outside EXEC.
- The mode bit is carried through the FSM only. Branch and load variants share paths; the datapath uses mode.
- Exactly one pc_wr pulse per instruction, always coincident with instr_done.
- Reset asserted mid-instruction (any state): next cycle is FETCH with no strobes. A pending memory write is dropped.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ADD..OP_SV)
  - state encodings
  - PC_SRC_* and WB_SEL_* encodings
  - opcode class functions (is_alu, is_load, is_store, is_branch)
- These constants are shared with the main decoder.
- One natural sub-module: mem_wait_timer (counter, clear, timeout flag).

Test Plan:
- ADD with imem_ready high → states 0,1,2,4, then 0. reg_wr_en=1, wb_sel=0, pc_wr=1, pc_src=0 in cycle 4 only. instr_done once.
- LW with dmem_ready low for 2 MEM cycles → mem_rd_en high 3 cycles, then WB with wb_sel=1. 7 cycles total.
- BEQ (opcode 8) with branch_taken=1 → pc_wr, pc_src=1 in EXEC. Repeat with 0 → pc_src=0. reg_wr_en is never high.
- CALL(13) → DECODE then WB with reg_wr_en=1, wb_sel=2, pc_src=2. JMP → pc_src=2 in DECODE. RET → pc_src=3 in DECODE.
- SW with dmem_ready stuck 0 → mem_wr_en high 16 cycles, mem_err pulse on the 16th, pc_src=0, next state FETCH, counter back to 0.
- Reset asserted during the 2nd MEM cycle of SV → next cycle state=0 and all strobes 0. A subsequent ADD completes normally in 4 cycles.
